// File: rtl/aes_ksa_pkg.sv
// Shared definitions for the AES key-schedule readers: key-length encodings,
// round counts, expanded-key sizes, memory latency and reader FSM states.
package aes_ksa_pkg;

  localparam logic [1:0] LEN_128     = 2'b00;
  localparam logic [1:0] LEN_128_ALT = 2'b01;
  localparam logic [1:0] LEN_192     = 2'b10;
  localparam logic [1:0] LEN_256     = 2'b11;

  localparam int MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_FETCH,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      LEN_192: nr_of = 4'd12;
      LEN_256: nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] words_of(input logic [1:0] len);
    case (len)
      LEN_192: words_of = 6'd52;
      LEN_256: words_of = 6'd60;
      default: words_of = 6'd44;
    endcase
  endfunction

endpackage

// File: rtl/aes_rk_addr_gen.sv
// Round index keeper: latches key length and direction at session start,
// steps r toward the final round and forms word address 4r+k.
module aes_rk_addr_gen
  import aes_ksa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] length,
  input  logic       decrypt,
  input  logic       step,
  input  logic       use_nxt,
  input  logic [1:0] k,
  output logic [3:0] r,
  output logic [5:0] addr,
  output logic       last
);

  logic [1:0] len_q;
  logic       dec_q;
  logic [3:0] r_nxt;

  always_comb begin
    last  = dec_q ? (r == 4'd0) : (r == nr_of(len_q));
    r_nxt = dec_q ? r - 4'd1 : r + 4'd1;
    // use_nxt lets the FSM prefetch the following round straight from DELIVER
    addr  = {(use_nxt ? r_nxt : r), k};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= LEN_128;
      dec_q <= 1'b0;
      r     <= 4'd0;
    end else if (load) begin
      len_q <= length;
      dec_q <= decrypt;
      r     <= decrypt ? nr_of(length) : 4'd0;
    end else if (step && !last) begin
      r <= r_nxt;
    end
  end

endmodule

// File: rtl/aes_round_key_reader.sv
// Reads 128-bit round keys out of the expanded-key word memory, one per req
// (or back-to-back when AES_RK_AUTO_EN is defined), in encrypt or decrypt order.
module aes_round_key_reader
  import aes_ksa_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   length,
  input  logic         keydone,
  input  logic         start,
  input  logic         decrypt,
  input  logic         req,
  output logic [5:0]   mem_addr,
  output logic         mem_rd_en,
  input  logic [31:0]  mem_rdata,
  output logic [127:0] round_key,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic         last_round,
  output logic         busy,
  output logic         err
);

`ifdef AES_RK_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  state_t     state;
  logic       cap_vld;
  logic [1:0] cap_idx;
  logic [1:0] k_sel;
  logic       use_nxt, load, step;
  logic [3:0] r;
  logic [5:0] addr;
  logic       last;

  always_comb begin
    k_sel   = (state == ST_FETCH) ? mem_addr[1:0] + 2'd1 : 2'd0;
    use_nxt = (state == ST_DELIVER);
    load    = (state == ST_IDLE) && start && keydone;
    step    = (state == ST_DELIVER) && keydone;
  end

  aes_rk_addr_gen u_addr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .length  (length),
    .decrypt (decrypt),
    .step    (step),
    .use_nxt (use_nxt),
    .k       (k_sel),
    .r       (r),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mem_addr   <= 6'd0;
      mem_rd_en  <= 1'b0;
      round_key  <= '0;
      rk_valid   <= 1'b0;
      rk_round   <= 4'd0;
      last_round <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      cap_vld    <= 1'b0;
      cap_idx    <= 2'd0;
    end else begin
      rk_valid   <= 1'b0;
      last_round <= 1'b0;
      mem_rd_en  <= 1'b0;
      err        <= 1'b0;
      // read data arrives one cycle after its address; low address bits pick the slice
      cap_vld    <= mem_rd_en;
      cap_idx    <= mem_addr[1:0];
      if (cap_vld && (state == ST_FETCH || state == ST_WAIT)) begin
        case (cap_idx)
          2'd0: round_key[127:96] <= mem_rdata;
          2'd1: round_key[95:64]  <= mem_rdata;
          2'd2: round_key[63:32]  <= mem_rdata;
          default: round_key[31:0] <= mem_rdata;
        endcase
      end

      if (state != ST_IDLE && start) err <= 1'b1;
      if (!AUTO && req && (state == ST_FETCH || state == ST_WAIT || state == ST_DELIVER))
        err <= 1'b1;

      if (state != ST_IDLE && !keydone) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (keydone) begin
                state <= ST_READY;
                busy  <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_READY: begin
            if (req) begin
              state     <= ST_FETCH;
              mem_addr  <= addr;
              mem_rd_en <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (mem_addr[1:0] == 2'd3) begin
              state <= ST_WAIT;
            end else begin
              mem_addr  <= addr;
              mem_rd_en <= 1'b1;
            end
          end
          ST_WAIT: begin
            state      <= ST_DELIVER;
            rk_valid   <= 1'b1;
            rk_round   <= r;
            last_round <= last;
          end
          ST_DELIVER: begin
            if (last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (AUTO) begin
              state     <= ST_FETCH;
              mem_addr  <= addr;
              mem_rd_en <= 1'b1;
            end else begin
              state <= ST_READY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_reader.sv
// Scoreboard bench for aes_round_key_reader; define AES_RK_AUTO_EN to run
// the back-to-back delivery case instead of the req-driven cases.
module tb_aes_round_key_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   length = 2'b00;
  logic         keydone = 1'b0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic         req = 1'b0;
  logic [5:0]   mem_addr;
  logic         mem_rd_en;
  logic [31:0]  mem_rdata = 32'd0;
  logic [127:0] round_key;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         last_round;
  logic         busy;
  logic         err;

  aes_round_key_reader dut (
    .clk        (clk),
    .rst        (rst),
    .length     (length),
    .keydone    (keydone),
    .start      (start),
    .decrypt    (decrypt),
    .req        (req),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .round_key  (round_key),
    .rk_valid   (rk_valid),
    .rk_round   (rk_round),
    .last_round (last_round),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // word n of the expanded key reads back as A000_0000 + n, one cycle late
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 32'hA000_0000 + {26'd0, mem_addr};

  typedef struct {
    logic [3:0]   round;
    logic         last;
    logic [127:0] key;
    int           when;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] aq[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [127:0] key_of(input int r);
    logic [31:0] b;
    b = 32'hA000_0000 + 32'(4 * r);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic push_key(input int r, input logic last, input int when);
    exp_t e;
    e.round = 4'(r);
    e.last  = last;
    e.key   = key_of(r);
    e.when  = when;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) aq.push_back(6'(4 * r + i));
  endtask

  // monitor: every delivered key and every issued address is popped and compared
  always @(negedge clk) begin
    if (rk_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rk_valid: round=%0d at cycle %0d, none expected", rk_round, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rk_round !== e.round || last_round !== e.last || round_key !== e.key || cyc != e.when) begin
          errors++;
          $display("FAIL key_r%0d: got round=%0d last=%0b key=%h cyc=%0d, want round=%0d last=%0b key=%h cyc=%0d",
                   e.round, rk_round, last_round, round_key, cyc, e.round, e.last, e.key, e.when);
        end
      end
    end
    if (mem_rd_en && aq.size() > 0) begin
      logic [5:0] a;
      a = aq.pop_front();
      checks++;
      if (mem_addr !== a) begin
        errors++;
        $display("FAIL mem_addr: got %0d want %0d", mem_addr, a);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic do_req(input int r, input logic last);
    push_key(r, last, cyc + 6);
    pulse_req();
    tick(7);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || aq.size() != 0) && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (sb.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d keys and %0d addresses still pending", sb.size(), aq.size());
      sb.delete();
      aq.delete();
    end
  endtask

  initial begin
    tick(3);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_rk_valid", 128'(rk_valid), 128'd0);
    check("reset_mem_rd_en", 128'(mem_rd_en), 128'd0);
    check("reset_mem_addr", 128'(mem_addr), 128'd0);
    check("reset_round_key", round_key, 128'd0);
    check("reset_err", 128'(err), 128'd0);
    rst = 1'b1;
    tick(1);

    // start without a valid key schedule
    keydone = 1'b0;
    pulse_start();
    check("nokey_err", 128'(err), 128'd1);
    check("nokey_busy", 128'(busy), 128'd0);
    tick(1);
    check("nokey_err_clear", 128'(err), 128'd0);
    check("nokey_busy_after", 128'(busy), 128'd0);

`ifndef AES_RK_AUTO_EN
    // AES-128 encrypt, rounds 0..10
    keydone = 1'b1;
    length  = 2'b00;
    decrypt = 1'b0;
    pulse_start();
    check("c1_busy", 128'(busy), 128'd1);
    for (int r = 0; r <= 10; r++) do_req(r, r == 10);
    drain(20);
    check("c1_idle", 128'(busy), 128'd0);

    // AES-256 decrypt, rounds 14..0
    length  = 2'b11;
    decrypt = 1'b1;
    pulse_start();
    for (int r = 14; r >= 0; r--) do_req(r, r == 0);
    drain(20);
    check("c2_idle", 128'(busy), 128'd0);

    // req during FETCH flags err and leaves the delivered key intact
    length  = 2'b00;
    decrypt = 1'b0;
    pulse_start();
    push_key(0, 1'b0, cyc + 6);
    pulse_req();
    tick(1);
    pulse_req();
    check("c4_req_fetch_err", 128'(err), 128'd1);
    tick(5);
    drain(20);
    pulse_start();
    check("c4_start_busy_err", 128'(err), 128'd1);
    check("c4_start_busy_busy", 128'(busy), 128'd1);

    // keydone drops mid-fetch
    pulse_req();
    tick(1);
    keydone = 1'b0;
    tick(1);
    check("c5_drop_busy", 128'(busy), 128'd0);
    check("c5_drop_rd_en", 128'(mem_rd_en), 128'd0);
    check("c5_drop_err", 128'(err), 128'd1);
    keydone = 1'b1;
    tick(10);
    pulse_start();
    do_req(0, 1'b0);
    drain(20);

    // reset mid-fetch
    pulse_req();
    tick(1);
    rst = 1'b0;
    tick(1);
    check("c5_rst_rd_en", 128'(mem_rd_en), 128'd0);
    check("c5_rst_busy", 128'(busy), 128'd0);
    check("c5_rst_round_key", round_key, 128'd0);
    rst = 1'b1;
    tick(10);
    pulse_start();
    do_req(0, 1'b0);
    drain(20);
`else
    // AES-192 encrypt, all 13 keys from a single req
    keydone = 1'b1;
    length  = 2'b10;
    decrypt = 1'b0;
    pulse_start();
    for (int r = 0; r <= 12; r++) push_key(r, r == 12, cyc + 6 + 6 * r);
    pulse_req();
    tick(1);
    pulse_req();
    check("c6_req_no_err", 128'(err), 128'd0);
    drain(120);
    check("c6_idle", 128'(busy), 128'd0);
`endif

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
